uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling from an internal bit counter.
// Define UART_RX_PARITY_EN to add an even-parity bit (PARITY state and parity_err port).
module uart_rx #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [SIZE-1:0] data_out,
  output logic            rx_done,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            rx_busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(SIZE + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state, w_state_next;
  logic            r_rx_m, r_rx_s, r_rx_prev;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [IW-1:0]   r_bit_idx, w_bit_idx_next;
  logic [SIZE-1:0] r_shift, w_shift_next;
  logic [SIZE-1:0] r_data, w_data_next;
  logic            r_done, w_done_next;
  logic            r_ferr, w_ferr_next;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bit, w_par_bit_next;
  logic            r_perr, w_perr_next;
`endif
  logic            w_half, w_full;

  assign w_half = (r_cnt == CW'(H - 1));
  assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
    w_ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_next = r_par_bit;
    w_perr_next    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Edge detect, not level: a held-low break never restarts a frame
        if (!r_rx_s && r_rx_prev) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rx_s, r_shift[SIZE-1:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == IW'(SIZE - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_cnt_next     = '0;
          w_par_bit_next = r_rx_s;
          w_state_next   = S_STOP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
          if (r_rx_s) begin
            w_data_next = r_shift;
            w_done_next = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_next = (^r_shift) ^ r_par_bit;
`endif
          end else begin
            w_ferr_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_rx_m    <= rx;
      r_rx_s    <= r_rx_m;
      r_rx_prev <= r_rx_s;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
      r_ferr    <= w_ferr_next;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= w_par_bit_next;
      r_perr    <= w_perr_next;
`endif
    end
  end

  assign data_out  = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table, hand-written corner cases, random frames
// against an arithmetic timing/data model.
module tb_uart_rx;

  localparam int SIZE = 8;
  localparam int C    = 16;
  localparam int H    = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = SIZE + 3;
`else
  localparam int NB = SIZE + 2;
`endif
  localparam int STOP_OFF = H + 2 + (NB - 1) * C;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [SIZE-1:0] data_out;
  logic            rx_done;
  logic            frame_err;
  logic            rx_busy;
  logic            perr_mon;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
  assign perr_mon = parity_err;
`else
  assign perr_mon = 1'b0;
`endif

  uart_rx #(.SIZE(SIZE), .CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .rx_done  (rx_done),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic     done;
    logic     ferr;
    logic     perr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbit;
    logic       exp_done;
    logic       exp_ferr;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        act_q[$];
  ev_t        exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  logic       busy_prev = 1'b0;
  logic [7:0] exp_last;
  vec_t       tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_busy === 1'b1 && busy_prev === 1'b0) rise_q.push_back(cyc);
    if (rx_busy === 1'b0 && busy_prev === 1'b1) fall_q.push_back(cyc);
    busy_prev <= rx_busy;
    if (rx_done === 1'b1 || frame_err === 1'b1) begin
      checks++;
      if (rx_done === 1'b1 && frame_err === 1'b1) begin
        errors++;
        $display("FAIL done_ferr_exclusive: both high at cycle %0d, required at most one", cyc);
      end
      act_q.push_back('{cyc, rx_done, frame_err, perr_mon, data_out});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_high(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is 1 time unit after a rising edge; t0 is the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit, output int t0);
    logic [15:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < SIZE; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[SIZE+1] = pbit;
    bits[SIZE+2] = stop;
`else
    bits[SIZE+1] = stop;
`endif
    t0 = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      rx = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  // Reference model: what the receiver must report for one complete frame.
  task automatic predict(input logic [7:0] d, input logic stop, input logic pbit, input int t0);
    ev_t e;
    e.cyc = t0 + STOP_OFF;
    if (stop) begin
      e.done = 1'b1;
      e.ferr = 1'b0;
      e.data = d;
`ifdef UART_RX_PARITY_EN
      e.perr = (^d) ^ pbit;
`else
      e.perr = 1'b0;
`endif
      exp_last = d;
    end else begin
      e.done = 1'b0;
      e.ferr = 1'b1;
      e.data = exp_last;
      e.perr = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string name);
    $display("%s: %0d event(s) seen, %0d expected, data_out=0x%02h", name, act_q.size(),
             exp_q.size(), data_out);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d required %0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].cyc != exp_q[i].cyc || act_q[i].done !== exp_q[i].done ||
          act_q[i].ferr !== exp_q[i].ferr || act_q[i].data !== exp_q[i].data ||
          act_q[i].perr !== exp_q[i].perr) begin
        errors++;
        $display("FAIL %s event%0d: got cyc=%0d done=%b ferr=%b perr=%b data=0x%02h required cyc=%0d done=%b ferr=%b perr=%b data=0x%02h",
                 name, i, act_q[i].cyc, act_q[i].done, act_q[i].ferr, act_q[i].perr, act_q[i].data,
                 exp_q[i].cyc, exp_q[i].done, exp_q[i].ferr, exp_q[i].perr, exp_q[i].data);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   t0;
    int   t1;
    logic [7:0] d;
    logic stop;
    logic pbit;
    ev_t  e;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    tbl[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1};
    tbl[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0};
    tbl[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0};

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset rx_done", 32'(rx_done), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    chk("reset rx_busy", 32'(rx_busy), 32'h0);
    sync_edge();
    rst = 1'b0;
    idle_high(2 * C);
    exp_last = 8'h00;
    act_q.delete();
    rise_q.delete();
    fall_q.delete();

    // Single frame 0xA5 with busy timing
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    predict(8'hA5, 1'b1, 1'b0, t0);
    idle_high(C);
    check_events("single A5");
    chk("A5 busy_rise", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 2);
    chk("A5 busy_fall", fall_q.size() > 0 ? fall_q[0] : -1, t0 + STOP_OFF);
    chk("A5 busy_after", 32'(rx_busy), 32'h0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].pbit, t0);
      e.cyc  = t0 + STOP_OFF;
      e.done = tbl[i].exp_done;
      e.ferr = tbl[i].exp_ferr;
      e.data = tbl[i].exp_data;
`ifdef UART_RX_PARITY_EN
      e.perr = tbl[i].exp_perr;
`else
      e.perr = 1'b0;
`endif
      exp_q.push_back(e);
      if (tbl[i].exp_done) exp_last = tbl[i].exp_data;
      idle_high(C);
      check_events($sformatf("table%0d data=0x%02h stop=%b", i, tbl[i].data, tbl[i].stop));
    end

    // Glitch: 3 low cycles must be rejected at the start-bit midpoint
    rise_q.delete();
    fall_q.delete();
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    while (cyc < t0 + H + 3) @(posedge clk);
    @(negedge clk);
    chk("glitch busy_low", 32'(rx_busy), 32'h0);
    chk("glitch busy_rise", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 2);
    chk("glitch busy_fall", fall_q.size() > 0 ? fall_q[0] : -1, t0 + H + 2);
    sync_edge();
    idle_high(2 * C);
    check_events("glitch");

    // Framing error followed by a long break
    send_frame(8'h11, 1'b1, 1'b0, t0);
    predict(8'h11, 1'b1, 1'b0, t0);
    idle_high(C);
    check_events("break pre 0x11");
    send_frame(8'h5A, 1'b0, 1'b0, t0);
    predict(8'h5A, 1'b0, 1'b0, t0);
    check_events("break 0x5A stop0");
    rise_q.delete();
    rx = 1'b0;
    repeat (40 * C) @(posedge clk);
    #1;
    chk("break busy_rises", rise_q.size(), 0);
    chk("break data_out", 32'(data_out), 32'h11);
    check_events("break hold");
    idle_high(C);
    send_frame(8'h66, 1'b1, 1'b0, t0);
    predict(8'h66, 1'b1, 1'b0, t0);
    idle_high(C);
    chk("break rearm_rise", rise_q.size(), 1);
    check_events("after break 0x66");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, t0);
    predict(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t1);
    predict(8'hFF, 1'b1, 1'b0, t1);
    idle_high(C);
    chk("b2b spacing", act_q.size() >= 2 ? act_q[1].cyc - act_q[0].cyc : -1, NB * C);
    check_events("back-to-back 00/FF");

    // Reset during data bit 3 of 0xC3; the transmitter side drops back to idle too
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (C + H) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst data_out", 32'(data_out), 32'h0);
    chk("midrst rx_done", 32'(rx_done), 32'h0);
    chk("midrst frame_err", 32'(frame_err), 32'h0);
    chk("midrst rx_busy", 32'(rx_busy), 32'h0);
`ifdef UART_RX_PARITY_EN
    chk("midrst parity_err", 32'(parity_err), 32'h0);
`endif
    exp_last = 8'h00;
    sync_edge();
    idle_high(12 * C);
    check_events("reset mid-frame C3");
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    predict(8'h3C, 1'b1, 1'b0, t0);
    idle_high(C);
    check_events("after reset 0x3C");

    // Random frames against the model
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      pbit = 1'($urandom_range(0, 1));
      send_frame(d, stop, pbit, t0);
      predict(d, stop, pbit, t0);
      check_events($sformatf("random%0d data=0x%02h stop=%b par=%b", k, d, stop, pbit));
      if (stop) idle_high($urandom_range(0, 2) * C);
      else      idle_high(C + $urandom_range(0, 2 * C));
    end
    idle_high(C);
    check_events("final quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
